// File: rtl/avmm_req_arbiter.sv
// ---------------------------------------------------------------------------
// avmm_req_arbiter
//
// Purpose
//   Shares a single start_op/op_done style AVMM transaction engine between
//   N_REQ requesters (link-init FSM, calibration, debug CSR access).
//   A round-robin arbiter picks one pending requester, captures its command,
//   fires one start_op pulse to the engine, waits for op_done and routes the
//   completion (and read data) back to the winner. A watchdog aborts an
//   engine that never answers and reports an error to the requester.
//
// Parameters
//   N_REQ           number of requesters (2..8)
//   TIMEOUT_CYCLES  max cycles spent in WAIT_DONE before abort; 0 disables
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   req_valid       per-requester request level
//   req_write       per-requester op type (1 = write, 0 = read)
//   req_addr        flattened 17-bit addresses, requester i at [i*17 +: 17]
//   req_wdata       flattened 32-bit write data
//   req_be          flattened 4-bit byte enables
//   req_ack         1-cycle pulse: command captured
//   req_done        1-cycle pulse: transaction finished
//   req_err         1-cycle pulse alongside req_done when the watchdog fired
//   rdata           read data, valid in the req_done cycle of a good read
//   eng_start_op    1-cycle start pulse to the engine
//   eng_is_write    captured op type, held through WAIT_DONE
//   eng_addr        captured address, held
//   eng_wdata       captured write data, held
//   eng_be          captured byte enables, held
//   eng_op_done     engine completion pulse (ignored outside WAIT_DONE)
//   eng_rdata       engine read data, sampled with eng_op_done
//   eng_abort       1-cycle pulse telling the engine to drop the hung op
//   busy            1 whenever the FSM is not in IDLE
//   fsm_state       current FSM state (IDLE=0, ISSUE=1, WAIT_DONE=2)
//
// Handshake
//   A requester raises req_valid with stable write/addr/wdata/be and keeps
//   them until it sees req_ack. Dropping req_valid before req_ack withdraws
//   the request. req_valid still high in the cycle after req_ack is treated
//   as a brand-new request. Exactly one transaction is outstanding at a time;
//   req_done (plus req_err on timeout) is pulsed to the requester that got
//   req_ack.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module avmm_req_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*17-1:0] req_addr,
  input  logic [N_REQ*32-1:0] req_wdata,
  input  logic [N_REQ*4-1:0]  req_be,
  output logic [N_REQ-1:0]    req_ack,
  output logic [N_REQ-1:0]    req_done,
  output logic [N_REQ-1:0]    req_err,
  output logic [31:0]         rdata,
  output logic                eng_start_op,
  output logic                eng_is_write,
  output logic [16:0]         eng_addr,
  output logic [31:0]         eng_wdata,
  output logic [3:0]          eng_be,
  input  logic                eng_op_done,
  input  logic [31:0]         eng_rdata,
  output logic                eng_abort,
  output logic                busy,
  output logic [1:0]          fsm_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Counter value in the final WAIT_DONE cycle before the watchdog fires.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  // Pointer starts at the last requester so that requester 0 wins first.
  localparam logic [PW-1:0] PTR_RST  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // ptr doubles as the owner of the outstanding transaction: it is loaded
  // with the winner on grant and does not move until the next grant.
  logic [PW-1:0]    ptr, ptr_next;
  logic [CW-1:0]    cnt, cnt_next;

  logic [N_REQ-1:0] ack_next, done_next, err_next;
  logic [31:0]      rdata_next;
  logic             start_next, abort_next, busy_next;
  logic             is_write_next;
  logic [16:0]      addr_next;
  logic [31:0]      wdata_next;
  logic [3:0]       be_next;

  // Round-robin search results
  logic             gnt_found;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    cand;
  logic [N_REQ-1:0] gnt_oh;
  logic [N_REQ-1:0] owner_oh;

  // Selected requester's command fields
  logic             gnt_write;
  logic [16:0]      gnt_addr;
  logic [31:0]      gnt_wdata;
  logic [3:0]       gnt_be;

  assign fsm_state = state;

  // -------------------------------------------------------------------------
  // Round-robin pick: first set req_valid bit starting at ptr+1, wrapping.
  // Visiting ptr itself last is what bounds the wait of a continuous
  // requester to N_REQ-1 other transactions.
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_oh           = '0;
    gnt_oh[gnt_idx]  = 1'b1;
    owner_oh         = '0;
    owner_oh[ptr]    = 1'b1;
  end

  always_comb begin
    gnt_write = req_write[gnt_idx];
    gnt_addr  = req_addr[int'(gnt_idx)*17 +: 17];
    gnt_wdata = req_wdata[int'(gnt_idx)*32 +: 32];
    gnt_be    = req_be[int'(gnt_idx)*4 +: 4];
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= PTR_RST;
      cnt          <= '0;
      req_ack      <= '0;
      req_done     <= '0;
      req_err      <= '0;
      rdata        <= '0;
      eng_start_op <= 1'b0;
      eng_is_write <= 1'b0;
      eng_addr     <= '0;
      eng_wdata    <= '0;
      eng_be       <= '0;
      eng_abort    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      cnt          <= cnt_next;
      req_ack      <= ack_next;
      req_done     <= done_next;
      req_err      <= err_next;
      rdata        <= rdata_next;
      eng_start_op <= start_next;
      eng_is_write <= is_write_next;
      eng_addr     <= addr_next;
      eng_wdata    <= wdata_next;
      eng_be       <= be_next;
      eng_abort    <= abort_next;
      busy         <= busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    cnt_next      = cnt;
    ack_next      = '0;
    done_next     = '0;
    err_next      = '0;
    start_next    = 1'b0;
    abort_next    = 1'b0;
    rdata_next    = rdata;
    is_write_next = eng_is_write;
    addr_next     = eng_addr;
    wdata_next    = eng_wdata;
    be_next       = eng_be;

    case (state)
      IDLE: begin
        if (gnt_found) begin
          ack_next      = gnt_oh;
          ptr_next      = gnt_idx;
          is_write_next = gnt_write;
          addr_next     = gnt_addr;
          wdata_next    = gnt_wdata;
          be_next       = gnt_be;
          state_next    = ISSUE;
        end
      end

      ISSUE: begin
        start_next = 1'b1;
        cnt_next   = '0;
        state_next = WAIT_DONE;
      end

      WAIT_DONE: begin
        cnt_next = cnt + CW'(1);
        // op_done is checked first so a completion landing exactly in the
        // expiry cycle is reported as a normal, error-free finish.
        if (eng_op_done) begin
          done_next = owner_oh;
          if (!eng_is_write) begin
            rdata_next = eng_rdata;
          end
          state_next = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          done_next  = owner_oh;
          err_next   = owner_oh;
          abort_next = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_avmm_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avmm_req_arbiter
//
// Self-checking bench for avmm_req_arbiter with N_REQ=3, TIMEOUT_CYCLES=16.
// A vector table drives single transactions (write, read, timeout, expiry-
// cycle completion); hand-written sequences cover the stray op_done, reset
// in WAIT_DONE and a round-robin run with every requester active. Each
// expected completion {req_done, req_err, rdata} is queued when the request
// is driven and popped by a monitor when req_done pulses.
// ---------------------------------------------------------------------------
module tb_avmm_req_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;
  localparam int W  = 2*N + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_valid, req_write;
  logic [N*17-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_be;
  logic [N-1:0]    req_ack, req_done, req_err;
  logic [31:0]     rdata;
  logic            eng_start_op, eng_is_write;
  logic [16:0]     eng_addr;
  logic [31:0]     eng_wdata;
  logic [3:0]      eng_be;
  logic            eng_op_done;
  logic [31:0]     eng_rdata;
  logic            eng_abort, busy;
  logic [1:0]      fsm_state;

  avmm_req_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .req_ack      (req_ack),
    .req_done     (req_done),
    .req_err      (req_err),
    .rdata        (rdata),
    .eng_start_op (eng_start_op),
    .eng_is_write (eng_is_write),
    .eng_addr     (eng_addr),
    .eng_wdata    (eng_wdata),
    .eng_be       (eng_be),
    .eng_op_done  (eng_op_done),
    .eng_rdata    (eng_rdata),
    .eng_abort    (eng_abort),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int          m_ptr;            // model round-robin pointer
  logic [31:0] m_rdata;          // model of the rdata register

  typedef struct {
    int          r;
    bit          wr;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;          // cycles from start_op to op_done; 0 = engine silent
    logic [31:0] rd;             // engine read data
    bit          exp_err;
    int          exp_lat;        // cycles from start_op to req_done
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // ---------------- monitor: pop on every req_done ----------------
  always @(negedge clk) begin
    if (!rst && req_done != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got done=%b err=%b rdata=0x%0h, expected no completion",
                 req_done, req_err, rdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_done", 64'({req_done, req_err, rdata}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input bit wr, input logic [16:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    req_write[r]          = wr;
    req_addr[r*17 +: 17]  = a;
    req_wdata[r*32 +: 32] = d;
    req_be[r*4 +: 4]      = b;
    req_valid[r]          = 1'b1;
  endtask

  task automatic scramble_req(input int r);
    req_valid[r]          = 1'b0;
    req_write[r]          = 1'($urandom_range(0, 1));
    req_addr[r*17 +: 17]  = 17'($urandom);
    req_wdata[r*32 +: 32] = $urandom;
    req_be[r*4 +: 4]      = 4'($urandom_range(0, 15));
  endtask

  // Waits (bounded) for any req_ack, checks it went to requester r.
  task automatic wait_grant(input int r, input int exp_lat, output bit got);
    int lat;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("ack_seen", 64'(got), 64'(1));
    if (got) begin
      check("ack_grant", 64'(req_ack), 64'(oh(r)));
      check("ack_lat", 64'(lat), 64'(exp_lat));
      m_ptr = r;
    end
  endtask

  // Called in the req_ack cycle: checks the captured command, the start
  // pulse, plays the engine and checks completion timing and side signals.
  task automatic finish_txn(input int r, input bit wr, input logic [16:0] a,
                            input logic [31:0] d, input logic [3:0] b,
                            input int delay, input logic [31:0] rd,
                            input int exp_lat, input bit exp_err, input bit drop);
    bit got;
    int lat;
    check("eng_cmd", 64'({eng_is_write, eng_addr, eng_wdata, eng_be}), 64'({wr, a, d, b}));
    if (drop) scramble_req(r);
    @(negedge clk);
    check("start_pulse", 64'({eng_start_op, req_ack, busy}), 64'({1'b1, {N{1'b0}}, 1'b1}));
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (delay != 0 && c == delay) begin
        eng_op_done = 1'b1;
        eng_rdata   = rd;
      end
      @(negedge clk);
      eng_op_done = 1'b0;
      eng_rdata   = $urandom;
      if (req_done != '0) begin
        got = 1'b1;
        lat = c;
      end else if (c == 1) begin
        check("wait_hold", 64'({eng_start_op, eng_is_write, eng_addr, eng_wdata, eng_be}),
              64'({1'b0, wr, a, d, b}));
      end
    end
    check("done_seen", 64'(got), 64'(1));
    if (got) begin
      check("done_lat", 64'(lat), 64'(exp_lat));
      check("abort_busy", 64'({eng_abort, busy}), 64'({exp_err, 1'b0}));
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    exp_q.push_back({oh(v.r), (v.exp_err ? oh(v.r) : {N{1'b0}}), v.exp_rdata});
    m_rdata = v.exp_rdata;
    set_req(v.r, v.wr, v.addr, v.wdata, v.be);
    wait_grant(v.r, 1, got);
    if (got) finish_txn(v.r, v.wr, v.addr, v.wdata, v.be, v.delay, v.rd, v.exp_lat, v.exp_err, 1'b1);
    else     req_valid[v.r] = 1'b0;
  endtask

  // ---------------- main test ----------------
  initial begin
    bit got;
    int order[6];
    logic [31:0] rr_rd[6];
    int p;

    vecs[0] = '{r:0, wr:1, addr:17'h00204, wdata:32'hDEADBEEF, be:4'hF, delay:3,  rd:32'h0,
                exp_err:0, exp_lat:3,  exp_rdata:32'h0};
    vecs[1] = '{r:1, wr:0, addr:17'h00300, wdata:32'h0,        be:4'hF, delay:2,  rd:32'h12345678,
                exp_err:0, exp_lat:2,  exp_rdata:32'h12345678};
    vecs[2] = '{r:2, wr:1, addr:17'h1FFFF, wdata:32'hA5A5A5A5, be:4'h3, delay:1,  rd:32'hFFFFFFFF,
                exp_err:0, exp_lat:1,  exp_rdata:32'h12345678};
    vecs[3] = '{r:0, wr:0, addr:17'h00010, wdata:32'h0,        be:4'hF, delay:0,  rd:32'h0,
                exp_err:1, exp_lat:16, exp_rdata:32'h12345678};
    vecs[4] = '{r:1, wr:0, addr:17'h00020, wdata:32'h0,        be:4'hF, delay:4,  rd:32'hCAFEF00D,
                exp_err:0, exp_lat:4,  exp_rdata:32'hCAFEF00D};
    vecs[5] = '{r:2, wr:0, addr:17'h00400, wdata:32'h0,        be:4'hC, delay:16, rd:32'h0BADC0DE,
                exp_err:0, exp_lat:16, exp_rdata:32'h0BADC0DE};
    vecs[6] = '{r:0, wr:1, addr:17'h10000, wdata:32'h00000001, be:4'h8, delay:5,  rd:32'h77777777,
                exp_err:0, exp_lat:5,  exp_rdata:32'h0BADC0DE};

    rst         = 1'b1;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_be      = '0;
    eng_op_done = 1'b0;
    eng_rdata   = '0;
    m_ptr       = N - 1;
    m_rdata     = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({req_ack, req_done, req_err, rdata, eng_start_op, eng_is_write, eng_abort, busy, fsm_state}),
          64'(0));
    check("reset_eng_fields", 64'({eng_addr, eng_wdata, eng_be}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table: single transactions
    foreach (vecs[i]) run_vec(vecs[i]);

    // Stray op_done while IDLE must do nothing
    eng_op_done = 1'b1;
    eng_rdata   = 32'hFFFF0000;
    @(negedge clk);
    eng_op_done = 1'b0;
    @(negedge clk);
    check("stray_done", 64'({req_done, req_err, eng_abort, busy, req_ack, rdata}),
          64'({{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, {N{1'b0}}, m_rdata}));

    // Reset during WAIT_DONE: outputs clear at once, no completion issued
    set_req(1, 1'b0, 17'h00055, 32'h0, 4'hF);
    wait_grant(1, 1, got);
    req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("rst_async",
          64'({req_ack, req_done, req_err, rdata, eng_start_op, eng_is_write, eng_abort, busy, fsm_state}),
          64'(0));
    @(negedge clk);
    eng_op_done = 1'b1;          // late engine completion while in reset
    @(negedge clk);
    eng_op_done = 1'b0;
    rst         = 1'b0;
    m_ptr       = N - 1;
    m_rdata     = '0;
    @(negedge clk);
    check("post_rst_idle", 64'({busy, req_done, fsm_state}), 64'(0));

    // Both 0 and 1 pending after reset: 0 first, then 1
    exp_q.push_back({oh(0), {N{1'b0}}, 32'h0});
    exp_q.push_back({oh(1), {N{1'b0}}, 32'h55AA55AA});
    set_req(0, 1'b1, 17'h00ABC, 32'h13579BDF, 4'h1);
    set_req(1, 1'b0, 17'h00DEF, 32'h0, 4'hF);
    wait_grant(0, 1, got);
    if (got) finish_txn(0, 1'b1, 17'h00ABC, 32'h13579BDF, 4'h1, 2, 32'h0, 2, 1'b0, 1'b1);
    wait_grant(1, 1, got);
    if (got) finish_txn(1, 1'b0, 17'h00DEF, 32'h0, 4'hF, 3, 32'h55AA55AA, 3, 1'b0, 1'b1);
    req_valid = '0;
    m_rdata   = 32'h55AA55AA;

    // Round robin with every requester continuously requesting
    p = m_ptr;
    for (int k = 0; k < 6; k++) begin
      p        = (p + 1) % N;
      order[k] = p;
      rr_rd[k] = 32'hA0000000 + 32'(k);
      exp_q.push_back({oh(p), {N{1'b0}}, rr_rd[k]});
    end
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, 17'h00100 + 17'(i), 32'h11111111 * 32'(i + 1), 4'hF);
    end
    for (int k = 0; k < 6; k++) begin
      wait_grant(order[k], 1, got);
      if (!got) break;
      finish_txn(order[k], 1'b0, 17'h00100 + 17'(order[k]), 32'h11111111 * 32'(order[k] + 1), 4'hF,
                 2, rr_rd[k], 2, 1'b0, 1'b0);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    check("sb_drain", 64'(exp_q.size()), 64'(0));
    check("final_idle", 64'({busy, fsm_state}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion within 200000 ns");
    $fatal(1, "global timeout");
  end

endmodule
